instr_fetch: RTL
================

// Module: instr_fetch
// ---------------------------------------------------------------------------
// PURPOSE
//  Initiator side of the instruction memory port. Holds the PC and drives read addresses to the
//  byte-addressed, little-endian instruction memory (read_write=0, 1-cycle registered read).
//  Buffers returned words with their PC in a small FIFO and presents them to decode over a
//  valid/ready handshake. Handles branch redirects and out-of-range fetch faults.
// PARAMETERS
//  PC_RESET    32'h01000000  PC loaded on reset
//  MEM_BASE    32'h01000000  lowest legal fetch address (memory offset 0)
//  MEM_BYTES   32'h00100000  memory size in bytes; legal range [MEM_BASE, MEM_BASE+MEM_BYTES-4]
//  FIFO_DEPTH  2             output buffer entries (power of 2, >=2); 2 sustains 1 instr/cycle
// PORTS
//  clock           in   1   single clock, all state on rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  imem_address    out  32  fetch byte address, equals PC register (combinational from reg)
//  imem_read_write out  1   tied 0 (read only)
//  imem_data_in    out  32  tied 0
//  imem_data_out   in   32  word at address sampled on previous edge
//  redirect_valid  in   1   branch/jump redirect request
//  redirect_target in   32  new PC; bits[1:0] must be 00
//  decode_valid    out  1   FIFO head valid for decode
//  decode_ready    in   1   decode accepts head this cycle
//  decode_pc       out  32  PC of head entry
//  decode_instr    out  32  instruction of head entry
//  fetch_fault     out  1   sticky: illegal/misaligned fetch; fetching halted
//  fault_pc        out  32  offending PC, valid while fetch_fault=1
// BEHAVIOUR
//  Reset (async assert): pc=PC_RESET, FIFO empty, inflight=0, state=RUN. Outputs:
//   decode_valid=0, decode_pc=0, decode_instr=0, fetch_fault=0, fault_pc=0,
//   imem_address=PC_RESET. Reset mid-operation drops all buffered and in-flight words.
//  Timing: address driven in cycle k; memory captures at edge k+1; word sits on imem_data_out
//   in cycle k+1; it is written into the FIFO at edge k+2. decode_valid rises in cycle k+2.
//  inflight: 1-bit register = "issued last cycle". It records the PC issued alongside it.
//  pop = decode_valid & decode_ready & ~redirect_valid.
//  issue = (state==RUN) & legal(pc) & ~redirect_valid & (count + inflight - pop < FIFO_DEPTH).
//   On issue: pc <= pc + 4 (32-bit, wraps at 2^32), inflight <= 1. Otherwise pc holds.
//  legal(pc) = pc>=MEM_BASE & pc<=MEM_BASE+MEM_BYTES-4 & pc[1:0]==0. Compute in 33 bits, no
//   overflow. Wrap 0xFFFFFFFC->0 therefore faults on the next issue attempt.
//  FIFO: write when inflight=1 and no kill. Read on pop. Simultaneous push+pop with count=DEPTH
//   is legal; the issue rule makes push to a full FIFO without pop impossible. Flag it as an
//   assertion error.
//  decode_valid = (count!=0) & ~redirect_valid. decode_pc/instr = head; they hold while valid
//   and not ready. They read 0 when empty.
//  FSM: RUN -> FAULT when state==RUN, ~redirect_valid and ~legal(pc).
//   In FAULT: fetch_fault=1, fault_pc=pc, no issue. Buffered words still drain to decode.
//   FAULT -> RUN only on redirect_valid.
//  Redirect (any state, priority over everything): at the edge, FIFO flushed (count=0),
//   inflight=0, and the word returning next cycle is discarded. pc <= redirect_target,
//   state=RUN, fetch_fault=0, fault_pc=0. No decode transfer occurs in the redirect cycle.
//   The target is issued in the following cycle if legal. Otherwise FAULT is entered then.
//   Back-to-back redirects: the last one wins.
// TESTING
//  1 Reset release, decode_ready=1, memory preloaded with 0x00000013 at each word ->
//    decode_pc 0x01000000,0x01000004,... one per cycle from cycle 2, no gaps.
//  2 decode_ready=0 for 5 cycles after first valid -> count saturates at 2, imem_address frozen,
//    head unchanged. Ready=1 -> pc order contiguous, no loss or duplication.
//  3 redirect_valid with target 0x01000100 while count=2 and inflight=1 -> decode_valid=0 that
//    cycle. Next valid decode_pc=0x01000100 two cycles later; stale words never appear.
//  4 redirect to 0x010FFFFC -> that word is delivered, then fetch_fault=1,
//    fault_pc=0x01100000. Redirect to 0x01000000 clears the fault and resumes fetch.
//  5 redirect to 0x01000002 -> fetch_fault=1, fault_pc=0x01000002, and no decode_valid.
//    redirect to 0x00FFFFFC -> fetch_fault=1.
//  6 reset_n low mid-stream while count=2 -> outputs reset immediately (async).
//    Refetch from 0x01000000 after release.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-unit bus bundling the instruction-memory read port, the redirect request
// and the decode valid/ready handshake.
//   master (fetch unit): drives imem_address/read_write/data_in, decode_valid/pc/instr,
//                        fetch_fault/fault_pc; samples imem_data_out, redirect_*, decode_ready
//   slave  (memory + decode + branch side): the mirror image
interface instr_fetch_if;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        decode_valid;
    logic        decode_ready;
    logic [31:0] decode_pc;
    logic [31:0] decode_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    modport master (
        output imem_address, imem_read_write, imem_data_in,
        output decode_valid, decode_pc, decode_instr, fetch_fault, fault_pc,
        input  imem_data_out, redirect_valid, redirect_target, decode_ready
    );
    modport slave (
        input  imem_address, imem_read_write, imem_data_in,
        input  decode_valid, decode_pc, decode_instr, fetch_fault, fault_pc,
        output imem_data_out, redirect_valid, redirect_target, decode_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: holds the PC, issues reads to the 1-cycle instruction memory, buffers returned
// words with their PC in a small FIFO for decode, and handles redirects and fetch faults.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : instr_fetch_if.master (memory read port, redirect request, decode handshake, fault)
module instr_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0100_0000,
    parameter logic [31:0] MEM_BASE   = 32'h0100_0000,
    parameter logic [31:0] MEM_BYTES  = 32'h0010_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic           clock,
    input logic           reset_n,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    typedef enum logic {RUN, FAULT} state_t;
    state_t        state, state_nxt;
    logic [31:0]   pc, inflight_pc;
    logic          inflight;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [63:0]   fifo [FIFO_DEPTH];
    logic [32:0]   hi_limit;
    logic [OW-1:0] occupancy;
    logic          legal, has_data, pop, push, issue;
    // Range check in 33 bits so the upper bound cannot overflow.
    assign hi_limit  = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES} - 33'd4;
    assign legal     = ({1'b0, pc} >= {1'b0, MEM_BASE}) && ({1'b0, pc} <= hi_limit) && (pc[1:0] == 2'b00);
    assign has_data  = count != '0;
    assign pop       = has_data && bus.decode_ready && !bus.redirect_valid;
    // The word returning while a redirect is asserted belongs to the old stream.
    assign push      = inflight && !bus.redirect_valid;
    // Slots committed after this edge: buffered + returning - leaving; one more issue must still fit.
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign issue     = (state == RUN) && legal && !bus.redirect_valid && (occupancy < OW'(FIFO_DEPTH));
    assign bus.imem_address    = pc;
    assign bus.imem_read_write = 1'b0;
    assign bus.imem_data_in    = '0;
    assign bus.decode_valid    = has_data && !bus.redirect_valid;
    assign {bus.decode_pc, bus.decode_instr} = has_data ? fifo[rd_ptr] : 64'd0;
    assign bus.fetch_fault     = state == FAULT;
    assign bus.fault_pc        = (state == FAULT) ? pc : 32'd0;
    always_comb begin
        state_nxt = state;
        state_nxt = bus.redirect_valid ? RUN : ((state == RUN) && !legal) ? FAULT : state;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (bus.redirect_valid) begin
                pc     <= bus.redirect_target;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (issue) pc <= pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr] <= {inflight_pc, bus.imem_data_out};
    end
    // The issue rule reserves a slot for every in-flight word, so a full FIFO is only pushed while popping.
    assert property (@(posedge clock) disable iff (!reset_n) !(push && !pop && count == CW'(FIFO_DEPTH)));
endmodule
